// File: rtl/johnson_seq_monitor.sv
// Johnson-code integrity monitor: decodes, checks single-step advance, tracks lock and errors.
// Latency: all outputs registered 1 cycle after a code_vld sample. Optional JOHNSON_BIDIR_EN adds down-steps and dir.
// Backpressure: none, a sample is accepted on every code_vld cycle.
module johnson_seq_monitor #(
    parameter int WIDTH      = 6,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8,
    localparam int IDXW      = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] code_in,
    input  logic             code_vld,
    input  logic             clr_err,
    output logic [IDXW-1:0]  idx,
    output logic             idx_vld,
    output logic             locked,
    output logic             err_illegal,
    output logic             err_skip,
`ifdef JOHNSON_BIDIR_EN
    output logic             dir,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    localparam int N    = 2*WIDTH;
    localparam int RUNW = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [RUNW-1:0]   run_q, run_d;
    logic [IDXW-1:0]   idx_d, dec_idx, up_idx;
    logic              idx_vld_d, ill_d, skip_d, err_ev, legal;
    logic              step_up, step_dn;
    logic [ERR_W-1:0]  err_cnt_d;
    int                trans, ones;
`ifdef JOHNSON_BIDIR_EN
    logic [IDXW-1:0]   dn_idx;
    logic              dir_d;
`endif

    // Legal codes have at most one 0/1 boundary across the (non-circular) bit string.
    always_comb begin
        trans = 0;
        ones  = 0;
        for (int i = 0; i < WIDTH-1; i++) begin
            if (code_in[i] != code_in[i+1]) trans++;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (code_in[i]) ones++;
        end
        legal = (trans <= 1);
        if (code_in[WIDTH-1])
            dec_idx = IDXW'(ones);
        else if (ones == 0)
            dec_idx = '0;
        else
            dec_idx = IDXW'(N - ones);
    end

    // idx/idx_vld double as the previous-sample register.
    assign up_idx  = (idx == IDXW'(N-1)) ? '0 : idx + IDXW'(1);
    assign step_up = idx_vld && (dec_idx == up_idx);
`ifdef JOHNSON_BIDIR_EN
    assign dn_idx  = (idx == '0) ? IDXW'(N-1) : idx - IDXW'(1);
    assign step_dn = idx_vld && (dec_idx == dn_idx);
`else
    assign step_dn = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        idx_d     = idx;
        idx_vld_d = idx_vld;
        ill_d     = 1'b0;
        skip_d    = 1'b0;
        err_ev    = 1'b0;
`ifdef JOHNSON_BIDIR_EN
        dir_d     = dir;
`endif
        if (code_vld) begin
            if (!legal) begin
                ill_d     = 1'b1;
                err_ev    = 1'b1;
                idx_vld_d = 1'b0;
                run_d     = '0;
                state_d   = UNLOCKED;
            end else begin
                idx_d     = dec_idx;
                idx_vld_d = 1'b1;
                if (!idx_vld) begin
                    run_d = '0;
                end else if (dec_idx == idx) begin
                    run_d = run_q;
                end else if (step_up || step_dn) begin
`ifdef JOHNSON_BIDIR_EN
                    dir_d = step_up;
`endif
                    if (state_q == UNLOCKED) begin
                        if (run_q == RUNW'(LOCK_COUNT-1)) begin
                            state_d = LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUNW'(1);
                        end
                    end
                end else begin
                    run_d = '0;
                    if (state_q == LOCKED) begin
                        skip_d  = 1'b1;
                        err_ev  = 1'b1;
                        state_d = UNLOCKED;
                    end
                end
            end
        end
    end

    // Clear wins over a coincident error; the counter sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt;
        if (clr_err)
            err_cnt_d = '0;
        else if (err_ev && (err_cnt != {ERR_W{1'b1}}))
            err_cnt_d = err_cnt + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= UNLOCKED;
            run_q       <= '0;
            idx         <= '0;
            idx_vld     <= 1'b0;
            err_illegal <= 1'b0;
            err_skip    <= 1'b0;
            err_cnt     <= '0;
`ifdef JOHNSON_BIDIR_EN
            dir         <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            idx         <= idx_d;
            idx_vld     <= idx_vld_d;
            err_illegal <= ill_d;
            err_skip    <= skip_d;
            err_cnt     <= err_cnt_d;
`ifdef JOHNSON_BIDIR_EN
            dir         <= dir_d;
`endif
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Directed self-checking bench for johnson_seq_monitor (default instance plus an ERR_W=2 instance).
module tb_johnson_seq_monitor;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [5:0] code_in;
    logic       code_vld, clr_err;
    logic [3:0] idx;
    logic       idx_vld, locked, err_illegal, err_skip;
    logic [7:0] err_cnt;
    logic [5:0] code2;
    logic       vld2, clr_err2;
    logic [3:0] idx2;
    logic       idx_vld2, locked2, ill2, skip2;
    logic [1:0] ecnt2;
`ifdef JOHNSON_BIDIR_EN
    logic       dir, dir2;
`endif

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    johnson_seq_monitor dut (
        .clk(clk), .clr_n(clr_n), .code_in(code_in), .code_vld(code_vld), .clr_err(clr_err),
        .idx(idx), .idx_vld(idx_vld), .locked(locked), .err_illegal(err_illegal),
        .err_skip(err_skip),
`ifdef JOHNSON_BIDIR_EN
        .dir(dir),
`endif
        .err_cnt(err_cnt)
    );

    johnson_seq_monitor #(.ERR_W(2)) dut2 (
        .clk(clk), .clr_n(clr_n), .code_in(code2), .code_vld(vld2), .clr_err(clr_err2),
        .idx(idx2), .idx_vld(idx_vld2), .locked(locked2), .err_illegal(ill2),
        .err_skip(skip2),
`ifdef JOHNSON_BIDIR_EN
        .dir(dir2),
`endif
        .err_cnt(ecnt2)
    );

    function automatic logic [5:0] jc(input int i);
        case (i)
            0:  return 6'b000000;
            1:  return 6'b100000;
            2:  return 6'b110000;
            3:  return 6'b111000;
            4:  return 6'b111100;
            5:  return 6'b111110;
            6:  return 6'b111111;
            7:  return 6'b011111;
            8:  return 6'b001111;
            9:  return 6'b000111;
            10: return 6'b000011;
            11: return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic cyc(input logic [5:0] c, input logic v);
        code_in  = c;
        code_vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic [5:0] c, input logic v);
        code2 = c;
        vld2  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr_n = 1'b0; code_in = '0; code_vld = 1'b0; clr_err = 1'b0;
        code2 = '0; vld2 = 1'b0; clr_err2 = 1'b0;
        #2;
        asserts++;
        if ({idx, idx_vld, locked, err_illegal, err_skip, err_cnt} !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs: idx=%0d vld=%b lck=%b ill=%b skp=%b cnt=%0d, all required 0",
                     idx, idx_vld, locked, err_illegal, err_skip, err_cnt);
        end
`ifdef JOHNSON_BIDIR_EN
        asserts++;
        if (dir !== 1'b1) begin fails++; $display("FAIL reset_dir: got %b want 1", dir); end
`endif
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_lock;
        for (int k = 0; k < 6; k++) begin
            cyc(jc(k), 1'b1);
            asserts++;
            if (idx !== 4'(k) || idx_vld !== 1'b1) begin
                fails++;
                $display("FAIL lock_idx%0d: idx=%0d vld=%b want idx=%0d vld=1", k, idx, idx_vld, k);
            end
            asserts++;
            if (locked !== (k >= 3) || err_cnt !== 8'd0) begin
                fails++;
                $display("FAIL lock_state%0d: locked=%b cnt=%0d want locked=%b cnt=0", k, locked, err_cnt, k >= 3);
            end
        end
    endtask

    task automatic test_skip;
        cyc(6'b111000, 1'b1);
        asserts++;
        if ({err_skip, locked, err_illegal} !== 3'b100 || err_cnt !== 8'd1 || idx !== 4'd3) begin
            fails++;
            $display("FAIL skip_event: skp=%b lck=%b ill=%b cnt=%0d idx=%0d want 1 0 0 1 3",
                     err_skip, locked, err_illegal, err_cnt, idx);
        end
        cyc(6'b111000, 1'b0);
        asserts++;
        if (err_skip !== 1'b0 || idx !== 4'd3 || err_cnt !== 8'd1) begin
            fails++;
            $display("FAIL skip_pulse_drop: skp=%b idx=%0d cnt=%0d want 0 3 1", err_skip, idx, err_cnt);
        end
    endtask

    task automatic test_illegal;
        cyc(jc(4), 1'b1);
        cyc(jc(5), 1'b1);
        cyc(jc(6), 1'b1);
        asserts++;
        if (locked !== 1'b1) begin fails++; $display("FAIL relock_46: locked=%b want 1", locked); end
        cyc(6'b101010, 1'b1);
        asserts++;
        if ({err_illegal, idx_vld, locked, err_skip} !== 4'b1000 || err_cnt !== 8'd2) begin
            fails++;
            $display("FAIL illegal_event: ill=%b vld=%b lck=%b skp=%b cnt=%0d want 1 0 0 0 2",
                     err_illegal, idx_vld, locked, err_skip, err_cnt);
        end
        cyc(6'b000011, 1'b1);
        asserts++;
        if (idx !== 4'd10 || idx_vld !== 1'b1 || err_illegal !== 1'b0) begin
            fails++;
            $display("FAIL first_after_illegal: idx=%0d vld=%b ill=%b want 10 1 0", idx, idx_vld, err_illegal);
        end
        cyc(6'b000001, 1'b1);
        cyc(6'b000000, 1'b1);
        asserts++;
        if (locked !== 1'b0 || idx !== 4'd0) begin
            fails++;
            $display("FAIL wrap_not_yet_locked: locked=%b idx=%0d want 0 0", locked, idx);
        end
        cyc(6'b100000, 1'b1);
        asserts++;
        if (locked !== 1'b1 || idx !== 4'd1 || err_cnt !== 8'd2 || err_skip !== 1'b0) begin
            fails++;
            $display("FAIL wrap_relock: locked=%b idx=%0d cnt=%0d skp=%b want 1 1 2 0", locked, idx, err_cnt, err_skip);
        end
    endtask

    task automatic test_hold;
        cyc(jc(2), 1'b1);
        cyc(jc(3), 1'b1);
        cyc(jc(4), 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(jc(4), 1'b1);
            asserts++;
            if ({locked, err_skip, err_illegal} !== 3'b100 || idx !== 4'd4 || err_cnt !== 8'd2) begin
                fails++;
                $display("FAIL hold%0d: lck=%b skp=%b ill=%b idx=%0d cnt=%0d want 1 0 0 4 2",
                         k, locked, err_skip, err_illegal, idx, err_cnt);
            end
            cyc(6'b101010, 1'b0);
            asserts++;
            if (err_illegal !== 1'b0 || locked !== 1'b1 || idx_vld !== 1'b1) begin
                fails++;
                $display("FAIL hold_gap%0d: ill=%b lck=%b vld=%b want 0 1 1", k, err_illegal, locked, idx_vld);
            end
        end
    endtask

    task automatic test_async_reset;
        cyc(jc(4), 1'b0);
        asserts++;
        if (locked !== 1'b1 || err_cnt !== 8'd2) begin
            fails++;
            $display("FAIL pre_reset: locked=%b cnt=%0d want 1 2", locked, err_cnt);
        end
        #3;
        clr_n = 1'b0;
        #1;
        asserts++;
        if ({idx, idx_vld, locked, err_illegal, err_skip, err_cnt} !== 16'h0) begin
            fails++;
            $display("FAIL async_reset: idx=%0d vld=%b lck=%b ill=%b skp=%b cnt=%0d, all required 0",
                     idx, idx_vld, locked, err_illegal, err_skip, err_cnt);
        end
        @(negedge clk);
        clr_n = 1'b1;
        cyc(jc(5), 1'b0);
        asserts++;
        if (idx_vld !== 1'b0 || locked !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: vld=%b lck=%b want 0 0", idx_vld, locked);
        end
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 5; k++) begin
            cyc2(6'b101010, 1'b1);
            asserts++;
            if (ecnt2 !== ((k < 3) ? 2'(k + 1) : 2'd3) || ill2 !== 1'b1) begin
                fails++;
                $display("FAIL sat%0d: cnt=%0d ill=%b want %0d 1", k, ecnt2, ill2, (k < 3) ? k + 1 : 3);
            end
        end
        clr_err2 = 1'b1;
        cyc2(6'b010101, 1'b1);
        asserts++;
        if (ecnt2 !== 2'd0 || ill2 !== 1'b1) begin
            fails++;
            $display("FAIL clr_vs_err: cnt=%0d ill=%b want 0 1", ecnt2, ill2);
        end
        clr_err2 = 1'b0;
        cyc2(6'b000000, 1'b0);
        asserts++;
        if ({ill2, skip2, locked2, idx_vld2} !== 4'b0000 || ecnt2 !== 2'd0 || idx2 !== 4'd0) begin
            fails++;
            $display("FAIL sat_idle: ill=%b skp=%b lck=%b vld=%b cnt=%0d idx=%0d want all 0",
                     ill2, skip2, locked2, idx_vld2, ecnt2, idx2);
        end
`ifdef JOHNSON_BIDIR_EN
        asserts++;
        if (dir2 !== 1'b1) begin fails++; $display("FAIL sat_dir: got %b want 1", dir2); end
`endif
    endtask

    task automatic test_reverse;
`ifdef JOHNSON_BIDIR_EN
        cyc(jc(3), 1'b1);
        cyc(jc(2), 1'b1);
        cyc(jc(1), 1'b1);
        cyc(jc(0), 1'b1);
        asserts++;
        if (locked !== 1'b1 || dir !== 1'b0) begin
            fails++;
            $display("FAIL down_lock: locked=%b dir=%b want 1 0", locked, dir);
        end
        cyc(jc(11), 1'b1);
        asserts++;
        if (locked !== 1'b1 || dir !== 1'b0 || idx !== 4'd11 || err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL down_wrap: lck=%b dir=%b idx=%0d cnt=%0d want 1 0 11 0", locked, dir, idx, err_cnt);
        end
        cyc(jc(0), 1'b1);
        asserts++;
        if (locked !== 1'b1 || dir !== 1'b1 || err_skip !== 1'b0) begin
            fails++;
            $display("FAIL reversal_up: lck=%b dir=%b skp=%b want 1 1 0", locked, dir, err_skip);
        end
`else
        for (int k = 0; k < 4; k++) cyc(jc(k), 1'b1);
        asserts++;
        if (locked !== 1'b1) begin fails++; $display("FAIL rev_prelock: locked=%b want 1", locked); end
        cyc(jc(2), 1'b1);
        asserts++;
        if (err_skip !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd1 || idx !== 4'd2) begin
            fails++;
            $display("FAIL down_is_skip: skp=%b lck=%b cnt=%0d idx=%0d want 1 0 1 2", err_skip, locked, err_cnt, idx);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lock();
        test_skip();
        test_illegal();
        test_hold();
        test_async_reset();
        test_saturate();
        test_reverse();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
